// File: rtl/timestamp_capture_tx.sv
// timestamp_capture_tx: periodic sync pulse plus multi-channel edge timestamping,
// FIFO-buffered and sent out as multi-byte 8N1 UART frames.
module timestamp_capture_tx #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 14,
  parameter int PERIOD       = 10240,
  parameter int PULSE_W      = 2,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ext,
  output logic            ti,
  output logic            tx,
  output logic            busy,
  output logic            overflow,
  output logic [7:0]      drop_cnt
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EW   = CH_W + CNT_W;
  localparam int NB   = (CNT_W + 7) / 8;
  localparam int FW   = 8 * NB;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int LW   = $clog2(NB + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] C_PW   = CNT_W'(PULSE_W);
  localparam logic [CW-1:0]    C_BIT  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  logic [CNT_W-1:0] r_cnt;
  logic             r_ti;
  logic [N_CH-1:0]  r_s1, r_s2, r_s3, r_pend;
  logic [CNT_W-1:0] r_cap [N_CH];
  logic             r_ovf;
  logic [7:0]       r_drop;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;
  state_t           r_state;
  logic             r_tx, r_busy;
  logic [FW+7:0]    r_frame;
  logic [7:0]       r_sh;
  logic [2:0]       r_bit;
  logic [CW-1:0]    r_clk;
  logic [LW-1:0]    r_left;

  logic [N_CH-1:0]  w_edge, w_hold, w_drop, w_clr;
  logic [CH_W-1:0]  w_sel;
  logic [4:0]       w_ndrop;
  logic [8:0]       w_dsum;
  logic [EW-1:0]    w_rd;
  logic             w_full, w_empty, w_push, w_pop, w_bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ti  <= 1'b0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
    end else begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      r_ti  <= r_cnt < C_PW;
      r_s1  <= ext;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
    end
  end

  // lowest-index pending channel wins the FIFO slot
  always_comb begin
    w_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) w_sel = r_pend[i] ? CH_W'(i) : w_sel;
  end

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < N_CH; i++) w_ndrop = w_ndrop + 5'(w_drop[i]);
  end

  assign w_edge    = r_s2 & ~r_s3;
  assign w_full    = (r_wp - r_rp) == (AW+1)'(DEPTH);
  assign w_empty   = r_wp == r_rp;
  assign w_push    = (|r_pend) & ~w_full;
  assign w_clr     = w_push ? N_CH'(1) << w_sel : '0;
  assign w_hold    = r_pend & ~w_clr;
  assign w_drop    = w_edge & w_hold;
  assign w_dsum    = {1'b0, r_drop} + 9'(w_ndrop);
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_rd      = r_mem[r_rp[AW-1:0]];
  assign w_bit_end = r_clk == C_BIT;

  // a channel whose pend is being pushed this cycle can re-arm without a drop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
      r_drop <= '0;
      for (int i = 0; i < N_CH; i++) r_cap[i] <= '0;
    end else begin
      r_pend <= w_edge | w_hold;
      r_ovf  <= r_ovf | (|w_drop);
      r_drop <= w_dsum[8] ? 8'hFF : w_dsum[7:0];
      for (int i = 0; i < N_CH; i++) if (w_edge[i] && !w_hold[i]) r_cap[i] <= r_cnt;
    end
  end

  always_ff @(posedge clk) if (w_push) r_mem[r_wp[AW-1:0]] <= {w_sel, r_cap[w_sel]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      r_wp <= r_wp + (AW+1)'(w_push);
      r_rp <= r_rp + (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_frame <= '0;
      r_sh    <= '0;
      r_bit   <= '0;
      r_clk   <= '0;
      r_left  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_frame <= {4'hA, 4'(w_rd[EW-1 -: CH_W]), FW'(w_rd[CNT_W-1:0])};
          r_left  <= LW'(NB);
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_sh    <= r_frame[FW+7 -: 8];
          r_frame <= r_frame << 8;
          r_tx    <= 1'b0;
          r_clk   <= '0;
          r_state <= S_START;
        end
        S_START: begin
          r_clk <= w_bit_end ? '0 : r_clk + 1'b1;
          if (w_bit_end) begin
            r_tx    <= r_sh[0];
            r_sh    <= r_sh >> 1;
            r_bit   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_clk <= w_bit_end ? '0 : r_clk + 1'b1;
          if (w_bit_end) begin
            r_tx    <= (r_bit == 3'd7) ? 1'b1 : r_sh[0];
            r_sh    <= r_sh >> 1;
            r_bit   <= r_bit + 1'b1;
            r_state <= (r_bit == 3'd7) ? S_STOP : S_DATA;
          end
        end
        S_STOP: begin
          r_clk <= w_bit_end ? '0 : r_clk + 1'b1;
          if (w_bit_end) begin
            r_state <= (r_left != '0) ? S_LOAD : S_IDLE;
            r_busy  <= r_left != '0;
            if (r_left != '0) r_left <= r_left - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ti       = r_ti;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign overflow = r_ovf;
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_timestamp_capture_tx.sv
// tb_timestamp_capture_tx: directed and randomized checks of timestamp_capture_tx,
// with a UART receiver decoding tx into bytes compared against expected frames.
module tb_timestamp_capture_tx;
  localparam int PERIOD  = 20;
  localparam int PULSE_W = 2;
  localparam int CPB     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ext = '0;
  logic       ti, tx, busy, overflow;
  logic [7:0] drop_cnt;

  int compared = 0;
  int mismatched = 0;
  int n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int start_n[$];
  int m_ferr = 0, m_starts = 0, m_t = 0, busy_cyc = 0;
  bit m_act = 0;
  logic [7:0] m_byte;

  timestamp_capture_tx #(
    .N_CH(4), .CNT_W(14), .PERIOD(PERIOD), .PULSE_W(PULSE_W), .DEPTH(4), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .ext(ext), .ti(ti), .tx(tx), .busy(busy),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // edges since reset release; the DUT counter equals n % PERIOD
  always @(posedge clk) n <= rst ? 0 : n + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cyc++;
      if (rst) m_act = 0;
      else if (!m_act) begin
        if (tx === 1'b0) begin
          m_act = 1;
          m_t = 0;
          m_starts++;
          start_n.push_back(n);
        end
      end else begin
        m_t++;
        if (m_t % CPB == CPB / 2) begin
          if (m_t / CPB == 0) begin
            if (tx !== 1'b0) m_ferr++;
          end else if (m_t / CPB <= 8) m_byte[m_t / CPB - 1] = tx;
          else begin
            if (tx !== 1'b1) m_ferr++;
            rx_q.push_back(m_byte);
            m_act = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_phase(input int r);
    for (int i = 0; i < PERIOD && n % PERIOD != r; i++) tick(1);
  endtask

  task automatic drain(input int budget, output bit ok);
    int t = 0;
    while ((rx_q.size() < exp_q.size() || busy === 1'b1) && t < budget) begin
      tick(1);
      t++;
    end
    ok = t < budget;
    tick(2);
  endtask

  task automatic clear_rx();
    exp_q.delete();
    rx_q.delete();
    start_n.delete();
    m_ferr = 0;
    busy_cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ext = '0;
    tick(3);
    compared += 5;
    if (ti !== 1'b0) begin mismatched++; $display("FAIL reset_ti: got %b want 0", ti); end
    if (tx !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_free_run();
    logic want;
    rst = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      want = ((i - 1) % PERIOD) < PULSE_W;
      compared += 3;
      if (ti !== want) begin mismatched++; $display("FAIL free_ti: clk %0d got %b want %b", i, ti, want); end
      if (tx !== 1'b1) begin mismatched++; $display("FAIL free_tx: clk %0d got %b want 1", i, tx); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL free_busy: clk %0d got %b want 0", i, busy); end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_rx();
    exp_q = '{8'hA2, 8'h00, 8'h05};
    wait_phase(3);
    ext[2] = 1'b1;
    tick(2);
    ext[2] = 1'b0;
    drain(2000, ok);
    compared++;
    if (!ok || rx_q.size() != 3) begin mismatched++; $display("FAIL single_count: got %0d bytes want 3 (done=%b)", rx_q.size(), ok); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    compared += 2;
    if (m_ferr != 0) begin mismatched++; $display("FAIL single_framing: got %0d errors want 0", m_ferr); end
    if (busy_cyc != 123) begin mismatched++; $display("FAIL single_busy_len: got %0d want 123", busy_cyc); end
    for (int i = 1; i < start_n.size(); i++) begin
      compared++;
      if (start_n[i] - start_n[i-1] != 41) begin mismatched++; $display("FAIL single_byte_spacing%0d: got %0d want 41", i, start_n[i] - start_n[i-1]); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    clear_rx();
    exp_q = '{8'hA0, 8'h00, 8'h07, 8'hA3, 8'h00, 8'h07};
    wait_phase(5);
    ext = 4'b1001;
    tick(2);
    ext = '0;
    drain(2000, ok);
    compared += 2;
    if (!ok || rx_q.size() != 6) begin mismatched++; $display("FAIL simul_count: got %0d bytes want 6 (done=%b)", rx_q.size(), ok); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL simul_overflow: got %b want 0", overflow); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL simul_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_rx();
    exp_q = '{8'hA0, 8'h00, 8'h13, 8'hA1, 8'h00, 8'h00};
    wait_phase(17);
    ext[0] = 1'b1;
    tick(1);
    ext[1] = 1'b1;
    tick(2);
    ext = '0;
    drain(2000, ok);
    compared++;
    if (!ok || rx_q.size() != 6) begin mismatched++; $display("FAIL wrap_count: got %0d bytes want 6 (done=%b)", rx_q.size(), ok); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  // random burst masks at random counter phases; frames predicted from edge timing
  task automatic test_random();
    bit ok;
    logic [3:0] mask;
    int ts;
    for (int it = 0; it < 8; it++) begin
      clear_rx();
      wait_phase($urandom_range(0, PERIOD - 1));
      mask = 4'($urandom_range(1, 15));
      ts = (n + 2) % PERIOD;
      for (int c = 0; c < 4; c++) if (mask[c]) begin
        exp_q.push_back(8'hA0 | 8'(c));
        exp_q.push_back(8'((ts >> 8) & 8'h3F));
        exp_q.push_back(8'(ts & 8'hFF));
      end
      ext = mask;
      tick(1 + $urandom_range(0, 2));
      ext = '0;
      drain(3000, ok);
      compared++;
      if (!ok || rx_q.size() != exp_q.size()) begin mismatched++; $display("FAIL rand%0d_count: got %0d bytes want %0d", it, rx_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < rx_q.size()) begin
        compared++;
        if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int ts;
    clear_rx();
    ts = (n + 2) % PERIOD;
    exp_q = '{8'hA0, 8'(ts >> 8), 8'(ts)};
    ext[0] = 1'b1;
    tick(2);
    ext[0] = 1'b0;
    tick(5);
    for (int k = 0; k < 6; k++) begin
      ts = (n + 2) % PERIOD;
      if (k < 5) begin
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'(ts >> 8));
        exp_q.push_back(8'(ts));
      end
      ext[1] = 1'b1;
      tick(1);
      ext[1] = 1'b0;
      tick(2);
    end
    tick(5);
    compared += 3;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL ovf_busy_held: got %b want 1", busy); end
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    if (drop_cnt !== 8'd1) begin mismatched++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    drain(3000, ok);
    compared += 2;
    if (!ok || rx_q.size() != exp_q.size()) begin mismatched++; $display("FAIL ovf_count: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    foreach (exp_q[i]) if (i < rx_q.size()) begin
      compared++;
      if (rx_q[i] !== exp_q[i]) begin mismatched++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 300; k++) begin
      ext[1] = 1'b1;
      tick(1);
      ext[1] = 1'b0;
      tick(2);
    end
    tick(5);
    compared += 2;
    if (drop_cnt !== 8'd255) begin mismatched++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL sat_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    int t = 0;
    int s;
    while (busy !== 1'b0 && t < 1000) begin tick(1); t++; end
    s = m_starts;
    while (m_starts < s + 2 && t < 2000) begin tick(1); t++; end
    compared++;
    if (t >= 2000) begin mismatched++; $display("FAIL midrst_reach_byte1: got timeout want second byte start"); end
    tick(CPB + 3);
    rst = 1'b1;
    tick(1);
    compared += 4;
    if (tx !== 1'b1) begin mismatched++; $display("FAIL midrst_tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    if (drop_cnt !== 8'd0) begin mismatched++; $display("FAIL midrst_drop_cnt: got %0d want 0", drop_cnt); end
    tick(2);
    rst = 1'b0;
    clear_rx();
    s = m_starts;
    tick(400);
    compared += 3;
    if (rx_q.size() != 0) begin mismatched++; $display("FAIL midrst_no_frames: got %0d bytes want 0", rx_q.size()); end
    if (m_starts != s) begin mismatched++; $display("FAIL midrst_no_starts: got %0d starts want 0", m_starts - s); end
    if (busy_cyc != 0) begin mismatched++; $display("FAIL midrst_idle: got %0d busy clocks want 0", busy_cyc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_free_run();
    test_single();
    test_simultaneous();
    test_wrap();
    test_random();
    test_overflow();
    test_saturate();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
